// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side streaming block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

  // Width of the free-running accepted-beat counter.
  localparam int BEAT_CNT_W = 16;

  // Skid buffer occupancy; the encoding is relied on by the read-ahead
  // arithmetic in fifo_reader (occupancy used directly as a count).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer: words pushed at the tail, oldest word presented at the head.
// Latency: a pushed word is visible at head_data the cycle after push when the buffer was empty.
// Backpressure: caller must never push into a full buffer without popping in the same cycle.
//
// Ports:
//   clk_read   - clock, all state on rising edge
//   rst        - synchronous active-low reset (occupancy only; data storage is not reset)
//   push       - write push_data into the tail this cycle
//   push_data  - word to store
//   pop        - discard the head word this cycle (ignored when EMPTY)
//   head_data  - oldest stored word, don't-care while EMPTY
//   occupancy  - EMPTY / ONE / TWO
module skid_buf2 import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_read,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output occ_t                  occupancy
);

  occ_t                  occ_nxt;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;

  always_ff @(posedge clk_read) begin
    if (!rst) begin
      occupancy <= EMPTY;
    end else begin
      occupancy <= occ_nxt;
    end
  end

  always_comb begin
    occ_nxt = occupancy;
    case (occupancy)
      EMPTY: begin
        if (push) occ_nxt = ONE;
      end
      ONE: begin
        if (push && !pop)      occ_nxt = TWO;
        else if (pop && !push) occ_nxt = EMPTY;
      end
      TWO: begin
        if (pop && !push) occ_nxt = ONE;
      end
      default: occ_nxt = EMPTY;
    endcase
  end

  // Data storage carries no reset: contents are only meaningful while the
  // occupancy says they are.
  always_ff @(posedge clk_read) begin
    case (occupancy)
      EMPTY: begin
        if (push) head_q <= push_data;
      end
      ONE: begin
        if (push) begin
          // Simultaneous push and pop replaces the head directly.
          if (pop) head_q <= push_data;
          else     tail_q <= push_data;
        end
      end
      TWO: begin
        if (pop) begin
          head_q <= tail_q;
          if (push) tail_q <= push_data;
        end
      end
      default: begin
      end
    endcase
  end

  assign head_data = head_q;

endmodule

// File: rtl/fifo_reader.sv
// Drains a synchronous-read FIFO into a valid/ready stream with burst framing and a beat counter.
// Latency: 2 cycles from a non-empty FIFO to out_valid (read-enable cycle, capture cycle), then 1 beat/cycle.
// Backpressure: out_ready low holds the head word; reads stop once buffered plus in-flight words reach 2.
//
// Ports:
//   clk_read      - sole clock
//   rst           - synchronous active-low reset; also gates fifo_rd_en low
//   fifo_empty    - FIFO empty flag
//   fifo_rd_data  - FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    - FIFO pop request (combinational)
//   out_data      - stream data (oldest buffered word)
//   out_valid     - stream valid
//   out_ready     - stream accept
//   out_last      - final beat of each BURST_LEN burst
//   beat_count    - accepted beats since reset, wrapping
module fifo_reader import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk_read,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [BEAT_CNT_W-1:0] beat_count
);

  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  occ_t             occupancy;
  logic             pending;
  logic             pop;
  logic [2:0]       fill_nxt;
  logic [IDX_W-1:0] beat_idx;

  assign out_valid = (occupancy != EMPTY);
  assign pop       = out_valid & out_ready;

  // Words that will be held next cycle if nothing new is requested. Issuing
  // a read only while this is below 2 guarantees the in-flight word always
  // has a free slot when it lands, so the buffer never overflows.
  assign fill_nxt   = 3'(occupancy) + 3'(pending) - 3'(pop);
  assign fifo_rd_en = rst & ~fifo_empty & (fill_nxt < 3'd2);

  // pending marks that fifo_rd_data carries a word this cycle.
  always_ff @(posedge clk_read) begin
    if (!rst) begin
      pending <= 1'b0;
    end else begin
      pending <= fifo_rd_en;
    end
  end

  skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_read  (clk_read),
    .rst       (rst),
    .push      (pending),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head_data (out_data),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk_read) begin
    if (!rst) begin
      beat_idx   <= '0;
      beat_count <= '0;
    end else if (pop) begin
      beat_idx   <= (beat_idx == LAST_IDX) ? '0 : beat_idx + IDX_W'(1);
      beat_count <= beat_count + BEAT_CNT_W'(1);
    end
  end

  assign out_last = out_valid & (beat_idx == LAST_IDX);

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: behavioural synchronous-read FIFO, scoreboard of loaded words, negedge monitor.
// Latency: n/a.
// Backpressure: directed and random out_ready patterns.
module tb_fifo_reader;

  localparam int BL        = 4;
  localparam int MEM_DEPTH = 131072;

  logic        clk_read = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic [15:0] beat_count;

  always #5 clk_read = ~clk_read;

  fifo_reader #(
    .DATA_WIDTH (8),
    .BURST_LEN  (BL)
  ) dut (
    .clk_read     (clk_read),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .beat_count   (beat_count)
  );

  // Synchronous-read FIFO model: data appears the cycle after a pop.
  logic [7:0] fifo_mem [0:MEM_DEPTH-1];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk_read) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= fifo_mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: every word loaded into the FIFO is expected on the stream,
  // except words already read out of the FIFO when a reset discards them.
  logic [7:0]  exp_q [$];
  int          out_idx = 0;
  logic [15:0] exp_cnt = 16'd0;
  int          exp_idx = 0;
  bit          mon_en  = 1'b0;

  always @(negedge clk_read) begin
    logic [7:0] tmp;
    if (mon_en) begin
      check("beat_count", beat_count, exp_cnt);
      check("outstanding_le_2", ((rd_ptr - out_idx) <= 2), 1);
      check("no_underflow", fifo_rd_en & fifo_empty, 0);
      check("no_rd_in_reset", fifo_rd_en & ~rst, 0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_valid, 0);
        end else begin
          check("out_data", out_data, exp_q[0]);
          check("out_last", out_last, (exp_idx == BL - 1));
        end
      end else begin
        check("out_last_idle", out_last, 0);
      end
      if (!rst) begin
        while (out_idx < rd_ptr) begin
          tmp = exp_q.pop_front();
          out_idx++;
        end
        exp_cnt = 16'd0;
        exp_idx = 0;
      end else if (out_valid && out_ready) begin
        if (exp_q.size() > 0) tmp = exp_q.pop_front();
        out_idx++;
        exp_cnt = exp_cnt + 16'd1;
        exp_idx = (exp_idx + 1) % BL;
      end
    end
  end

  task automatic tick();
    @(posedge clk_read);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    fifo_mem[wr_ptr] = d;
    exp_q.push_back(d);
    wr_ptr++;
  endtask

  task automatic enter_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic leave_reset();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && fifo_empty) break;
      tick();
    end
    tick();
    check("drain", exp_q.size(), 0);
  endtask

  task automatic mid_reset(input logic rdy, input int nwords, input logic [7:0] base);
    out_ready = rdy;
    for (int i = 0; i < nwords; i++) load(base + 8'(i));
    repeat (5) tick();
    rst = 1'b0;
    @(negedge clk_read);
    check("mid_reset_rd_en", fifo_rd_en, 0);
    tick();
    rst = 1'b1;
    @(negedge clk_read);
    check("mid_reset_valid", out_valid, 0);
    check("mid_reset_count", beat_count, 0);
    out_ready = 1'b1;
    wait_drain(100);
  endtask

  initial begin
    int pops;
    int valids;

    // Streaming: eight words preloaded during reset.
    rst = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) load(8'(i));
    tick();
    tick();
    mon_en = 1'b1;
    @(negedge clk_read);
    check("reset_valid", out_valid, 0);
    check("reset_rd_en", fifo_rd_en, 0);
    check("reset_count", beat_count, 0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_read);
      if (c == 0) check("stream_first_rd_en", fifo_rd_en, 1);
      check("stream_valid", out_valid, (c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) begin
        check("stream_data", out_data, 8'(c - 1));
        check("stream_last", out_last, (c == 5 || c == 9));
      end
      if (c == 10) check("stream_count", beat_count, 8);
    end

    // Backpressure: five stalled cycles, then release.
    enter_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) load(8'(i));
    leave_reset();
    pops = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_read);
      pops += int'(fifo_rd_en);
      if (c >= 2) check("bp_hold_data", out_data, 8'h01);
    end
    check("bp_pops", pops, 2);
    tick();
    out_ready = 1'b1;
    for (int c = 5; c < 8; c++) begin
      if (c > 5) @(negedge clk_read);
      else       @(negedge clk_read);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 8'(c - 4));
    end
    wait_drain(50);

    // Empty boundary: a single word through an otherwise empty FIFO.
    tick();
    load(8'hA5);
    pops = 0;
    valids = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_read);
      pops   += int'(fifo_rd_en);
      valids += int'(out_valid);
    end
    check("empty_pops", pops, 1);
    check("empty_valids", valids, 1);
    check("empty_valid_end", out_valid, 0);
    check("empty_rd_en_end", fifo_rd_en, 0);
    check("empty_flag_end", fifo_empty, 1);

    // Mid-operation reset with a full buffer, then while streaming.
    mid_reset(1'b0, 6, 8'h30);
    mid_reset(1'b1, 10, 8'h50);

    // Counter wrap: 65537 beats.
    enter_reset();
    for (int i = 0; i < 65537; i++) load(8'(i * 3));
    leave_reset();
    out_ready = 1'b1;
    wait_drain(70000);
    @(negedge clk_read);
    check("wrap_count", beat_count, 1);

    // Random downstream readiness over 1000 words.
    enter_reset();
    for (int i = 0; i < 1000; i++) load(8'($urandom_range(0, 255)));
    leave_reset();
    for (int i = 0; i < 6000; i++) begin
      if (exp_q.size() == 0) break;
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    wait_drain(20);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
